// File: rtl/aes_ctr_rx_if.sv
// Handshake bundle for aes_ctr_rx: key control, frame header, ciphertext in, plaintext out,
// and the port to the shared AES encipher core.
interface aes_ctr_rx_if #(
    parameter int unsigned NONCE_W = 64,
    parameter int unsigned CTR_W   = 64
);
    logic [127:0]         key;
    logic                 key_init;
    logic                 key_loaded;
    logic                 abort;
    logic                 hdr_valid;
    logic                 hdr_ready;
    logic [NONCE_W-1:0]   hdr_nonce;
    logic [CTR_W-1:0]     hdr_count;
    logic                 ct_valid;
    logic                 ct_ready;
    logic [127:0]         ct_data;
    logic                 ct_last;
    logic                 pt_valid;
    logic                 pt_ready;
    logic [127:0]         pt_data;
    logic                 pt_last;
    logic                 ctr_wrap_err;
    logic                 core_init;
    logic                 core_next;
    logic [127:0]         core_block;
    logic [127:0]         core_result;
    logic                 core_ready;

    // key goes straight to the AES core; the engine only sequences core_init.
    modport slave (
        input  key_init, abort, hdr_valid, hdr_nonce, hdr_count, ct_valid, ct_data, ct_last,
               pt_ready, core_result, core_ready,
        output key_loaded, hdr_ready, ct_ready, pt_valid, pt_data, pt_last, ctr_wrap_err,
               core_init, core_next, core_block
    );

    modport master (
        output key, key_init, abort, hdr_valid, hdr_nonce, hdr_count, ct_valid, ct_data, ct_last,
               pt_ready, core_result, core_ready,
        input  key_loaded, hdr_ready, ct_ready, pt_valid, pt_data, pt_last, ctr_wrap_err,
               core_init, core_next, core_block
    );
endinterface

// File: rtl/aes_ctr_rx.sv
// Receive-side AES-CTR engine: sequences a shared AES core to produce AES(key, {nonce, ctr})
// keystream ahead of each ciphertext block and XORs it in to return plaintext.
module aes_ctr_rx #(
    parameter int unsigned NONCE_W = 64,
    parameter int unsigned CTR_W   = 64
) (
    input logic         clk,
    input logic         reset,
    aes_ctr_rx_if.slave bus
);
    typedef enum logic [3:0] {
        S_NOKEY, S_KINIT, S_KARM, S_KWAIT, S_HDR,
        S_KSGO, S_KSARM, S_KSWAIT, S_CT, S_OUT
    } state_e;

    state_e             state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [CTR_W-1:0]   ctr_q, ctr_d;
    logic [127:0]       ks_q, ks_d;
    logic [127:0]       pt_data_q, pt_data_d;
    logic               pt_valid_q, pt_valid_d;
    logic               pt_last_q, pt_last_d;
    logic               key_loaded_q, key_loaded_d;
    logic               wrap_err_q, wrap_err_d;
    logic               abort_q, abort_d;
    logic               hdr_ready, ct_ready, core_init, core_next;

    always_comb begin
        state_d      = state_q;
        nonce_d      = nonce_q;
        ctr_d        = ctr_q;
        ks_d         = ks_q;
        pt_data_d    = pt_data_q;
        pt_valid_d   = pt_valid_q;
        pt_last_d    = pt_last_q;
        key_loaded_d = key_loaded_q;
        wrap_err_d   = wrap_err_q;
        abort_d      = abort_q;
        hdr_ready    = 1'b0;
        ct_ready     = 1'b0;
        core_init    = 1'b0;
        core_next    = 1'b0;
        unique case (state_q)
            S_NOKEY: begin
                if (bus.key_init) begin
                    key_loaded_d = 1'b0;
                    wrap_err_d   = 1'b0;
                    state_d      = S_KINIT;
                end
            end
            S_KINIT: begin
                core_init = 1'b1;
                state_d   = S_KARM;
            end
            // core_ready may still read high in the cycle after a start pulse
            S_KARM: state_d = S_KWAIT;
            S_KWAIT: begin
                if (bus.core_ready) begin
                    key_loaded_d = 1'b1;
                    state_d      = S_HDR;
                end
            end
            S_HDR: begin
                hdr_ready = !bus.key_init;
                if (bus.key_init) begin
                    key_loaded_d = 1'b0;
                    wrap_err_d   = 1'b0;
                    state_d      = S_KINIT;
                end else if (bus.hdr_valid) begin
                    nonce_d = bus.hdr_nonce;
                    ctr_d   = bus.hdr_count;
                    state_d = S_KSGO;
                end
            end
            S_KSGO: begin
                // An abort here suppresses the start so the core is never left busy.
                if (bus.abort) begin
                    state_d = S_HDR;
                end else begin
                    core_next = 1'b1;
                    state_d   = S_KSARM;
                end
            end
            S_KSARM: begin
                if (bus.abort) abort_d = 1'b1;
                state_d = S_KSWAIT;
            end
            S_KSWAIT: begin
                if (bus.abort) abort_d = 1'b1;
                if (bus.core_ready) begin
                    abort_d = 1'b0;
                    if (abort_q || bus.abort) begin
                        state_d = S_HDR;
                    end else begin
                        ks_d    = bus.core_result;
                        state_d = S_CT;
                    end
                end
            end
            S_CT: begin
                if (bus.abort) begin
                    state_d = S_HDR;
                end else begin
                    ct_ready = 1'b1;
                    if (bus.ct_valid) begin
                        pt_data_d  = bus.ct_data ^ ks_q;
                        pt_last_d  = bus.ct_last;
                        pt_valid_d = 1'b1;
                        if (!bus.ct_last && (&ctr_q)) wrap_err_d = 1'b1;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (bus.abort) begin
                    pt_valid_d = 1'b0;
                    state_d    = S_HDR;
                end else if (bus.pt_ready) begin
                    pt_valid_d = 1'b0;
                    if (pt_last_q) begin
                        state_d = S_HDR;
                    end else begin
                        ctr_d   = ctr_q + CTR_W'(1);
                        state_d = S_KSGO;
                    end
                end
            end
            default: state_d = S_NOKEY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_NOKEY;
            nonce_q      <= '0;
            ctr_q        <= '0;
            ks_q         <= '0;
            pt_data_q    <= '0;
            pt_valid_q   <= 1'b0;
            pt_last_q    <= 1'b0;
            key_loaded_q <= 1'b0;
            wrap_err_q   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            nonce_q      <= nonce_d;
            ctr_q        <= ctr_d;
            ks_q         <= ks_d;
            pt_data_q    <= pt_data_d;
            pt_valid_q   <= pt_valid_d;
            pt_last_q    <= pt_last_d;
            key_loaded_q <= key_loaded_d;
            wrap_err_q   <= wrap_err_d;
            abort_q      <= abort_d;
        end
    end

    assign bus.hdr_ready    = hdr_ready;
    assign bus.ct_ready     = ct_ready;
    assign bus.core_init    = core_init;
    assign bus.core_next    = core_next;
    assign bus.core_block   = {nonce_q, ctr_q};
    assign bus.pt_valid     = pt_valid_q;
    assign bus.pt_data      = pt_data_q;
    assign bus.pt_last      = pt_last_q;
    assign bus.key_loaded   = key_loaded_q;
    assign bus.ctr_wrap_err = wrap_err_q;
endmodule

// File: tb/tb_aes_ctr_rx.sv
// Bench for aes_ctr_rx: behavioural AES-128 core with random latency, CTR reference model,
// SP800-38A vectors, backpressure, counter wrap, abort, key reload and mid-frame reset.
module tb_aes_ctr_rx;
    localparam logic [127:0] K = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    aes_ctr_rx_if #(.NONCE_W(64), .CTR_W(64)) bus ();
    aes_ctr_rx #(.NONCE_W(64), .CTR_W(64)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural AES-128 ----------------
    logic [7:0] sbox_t [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
            end
            sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] blk);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tw [4];
        logic [7:0] rc, tmp, a0, a1, a2, a3;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127-8*i -: 8];
            s[i] = blk[127-8*i -: 8];
        end
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tw[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                tmp   = tw[0];
                tw[0] = sbox_t[tw[1]] ^ rc;
                tw[1] = sbox_t[tw[2]];
                tw[2] = sbox_t[tw[3]];
                tw[3] = sbox_t[tmp];
                rc    = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tw[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 4; k++) s[4*c+k] = t[4*((c+k)%4)+k];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // ---------------- AES core model: busy for tlow cycles per operation ----------------
    logic [127:0] core_key, core_blk;
    logic [127:0] mdl_result;
    logic         mdl_ready;
    logic         next_busy;
    int           busy;
    int           last_tlow = 0;
    int           next_count = 0;
    int           force_tlow = 0;
    int           tlow_pick = 1;

    always @(negedge clk) tlow_pick = (force_tlow != 0) ? force_tlow : int'($urandom_range(1, 5));

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdl_ready  <= 1'b1;
            mdl_result <= '0;
            busy       <= 0;
            next_busy  <= 1'b0;
        end else if (bus.core_init) begin
            core_key  <= bus.key;
            busy      <= tlow_pick;
            last_tlow <= tlow_pick;
            mdl_ready <= 1'b0;
            next_busy <= 1'b0;
        end else if (bus.core_next) begin
            core_blk   <= bus.core_block;
            busy       <= tlow_pick;
            last_tlow  <= tlow_pick;
            mdl_ready  <= 1'b0;
            next_busy  <= 1'b1;
            next_count <= next_count + 1;
        end else if (busy == 1) begin
            mdl_ready  <= 1'b1;
            busy       <= 0;
            next_busy  <= 1'b0;
            mdl_result <= aes_enc(core_key, core_blk);
        end else if (busy > 1) begin
            busy <= busy - 1;
        end
    end

    assign bus.core_ready  = mdl_ready;
    assign bus.core_result = mdl_result;

    logic prev_init = 1'b0;
    logic prev_next = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (bus.core_init | bus.core_next) begin
            check_eq("init_next_excl", bus.core_init & bus.core_next, 0);
            check_eq("pulse_width", (bus.core_init & prev_init) | (bus.core_next & prev_next), 0);
        end
        if (next_busy && !mdl_ready) check_eq("blk_stable", bus.core_block, core_blk);
        prev_init <= bus.core_init;
        prev_next <= bus.core_next;
    end

    // ---------------- stimulus helpers ----------------
    logic [127:0] ct_blk [8];
    logic [127:0] pt_got [8];
    logic [127:0] blk_seen [8];
    logic         exp_wrap = 1'b0;

    task automatic check_reset_state();
        check_eq("rst_key_loaded", bus.key_loaded, 0);
        check_eq("rst_hdr_ready", bus.hdr_ready, 0);
        check_eq("rst_ct_ready", bus.ct_ready, 0);
        check_eq("rst_pt_valid", bus.pt_valid, 0);
        check_eq("rst_pt_data", bus.pt_data, 0);
        check_eq("rst_pt_last", bus.pt_last, 0);
        check_eq("rst_wrap_err", bus.ctr_wrap_err, 0);
        check_eq("rst_core_init", bus.core_init, 0);
        check_eq("rst_core_next", bus.core_next, 0);
        check_eq("rst_core_block", bus.core_block, 0);
    endtask

    task automatic load_key();
        int n;
        n = 0;
        bus.key_init = 1'b1;
        @(negedge clk);
        bus.key_init = 1'b0;
        check_eq("key_loaded_drop", bus.key_loaded, 0);
        while (!bus.key_loaded && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("key_loaded", bus.key_loaded, 1);
        check_eq("wrap_err_clear", bus.ctr_wrap_err, 0);
        exp_wrap = 1'b0;
    endtask

    task automatic send_hdr(input logic [63:0] nonce, input logic [63:0] count,
                            output int h, output bit ok);
        int n;
        n = 0;
        bus.hdr_nonce = nonce;
        bus.hdr_count = count;
        bus.hdr_valid = 1'b1;
        #1;
        while (!bus.hdr_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = bus.hdr_ready;
        h = cyc;
        check_eq("hdr_ready_wait", bus.hdr_ready, 1);
        @(negedge clk);
        bus.hdr_valid = 1'b0;
    endtask

    task automatic wait_ct_ready(output bit ok);
        int n;
        n = 0;
        while (!bus.ct_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = bus.ct_ready;
        check_eq("ct_ready_wait", bus.ct_ready, 1);
    endtask

    // Expected plaintext is ct ^ AES(K, {nonce, count + i}); latency is 3 + busy cycles.
    task automatic run_frame(input logic [63:0] nonce, input logic [63:0] count,
                             input int nblk, input int hold);
        int h, t0, nc;
        bit ok;
        logic [63:0] ctr;
        logic [127:0] exp;
        send_hdr(nonce, count, h, ok);
        if (!ok) return;
        t0 = h;
        ctr = count;
        for (int i = 0; i < nblk; i++) begin
            wait_ct_ready(ok);
            if (!ok) return;
            check_eq("ct_latency", cyc - t0, 3 + last_tlow);
            blk_seen[i] = core_blk;
            check_eq("core_block", core_blk, {nonce, ctr});
            bus.ct_valid = 1'b1;
            bus.ct_data  = ct_blk[i];
            bus.ct_last  = (i == nblk - 1);
            if (i != nblk - 1 && ctr == 64'hffff_ffff_ffff_ffff) exp_wrap = 1'b1;
            exp = ct_blk[i] ^ aes_enc(K, {nonce, ctr});
            @(negedge clk);
            bus.ct_valid = 1'b0;
            bus.ct_last  = 1'b0;
            check_eq("pt_valid", bus.pt_valid, 1);
            check_eq("pt_data", bus.pt_data, exp);
            check_eq("pt_last", bus.pt_last, (i == nblk - 1));
            check_eq("wrap_err", bus.ctr_wrap_err, exp_wrap);
            pt_got[i] = bus.pt_data;
            nc = next_count;
            repeat (hold) begin
                @(negedge clk);
                check_eq("hold_pt_valid", bus.pt_valid, 1);
                check_eq("hold_pt_data", bus.pt_data, exp);
                check_eq("hold_ct_ready", bus.ct_ready, 0);
            end
            if (hold > 0) check_eq("hold_no_next", next_count, nc);
            bus.pt_ready = 1'b1;
            t0 = cyc;
            @(negedge clk);
            bus.pt_ready = 1'b0;
            ctr = ctr + 64'd1;
        end
        check_eq("frame_end_pt_valid", bus.pt_valid, 0);
        check_eq("frame_end_hdr_ready", bus.hdr_ready, 1);
    endtask

    task automatic rand_frame();
        logic [63:0] nonce, count;
        int nblk;
        nonce = {$urandom, $urandom};
        count = ($urandom_range(0, 3) == 0) ? 64'hffff_ffff_ffff_fffe : {$urandom, $urandom};
        nblk  = $urandom_range(1, 4);
        for (int i = 0; i < nblk; i++) ct_blk[i] = {$urandom, $urandom, $urandom, $urandom};
        run_frame(nonce, count, nblk, $urandom_range(0, 3));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    localparam logic [63:0] N0 = 64'hf0f1f2f3f4f5f6f7;
    localparam logic [63:0] C0 = 64'hf8f9fafbfcfdfeff;

    initial begin
        int h, nc, n;
        bit ok;
        build_sbox();
        bus.key = K; bus.key_init = 0; bus.abort = 0;
        bus.hdr_valid = 0; bus.hdr_nonce = '0; bus.hdr_count = '0;
        bus.ct_valid = 0; bus.ct_data = '0; bus.ct_last = 0; bus.pt_ready = 0;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b1;
        @(negedge clk);
        check_eq("nokey_hdr_ready", bus.hdr_ready, 0);
        load_key();

        // SP800-38A F.5.1 blocks 1 and 2
        ct_blk[0] = 128'h874d6191b620e3261bef6864990db6ce;
        run_frame(N0, C0, 1, 0);
        check_eq("vec_pt1", pt_got[0], 128'h6bc1bee22e409f96e93d7e117393172a);
        ct_blk[1] = 128'h9806f66b7970fdff8617187bb9fffdff;
        run_frame(N0, C0, 2, 0);
        check_eq("vec2_pt1", pt_got[0], 128'h6bc1bee22e409f96e93d7e117393172a);
        check_eq("vec2_pt2", pt_got[1], 128'hae2d8a571e03ac9c9eb76fac45af8e51);
        check_eq("vec2_ctr2", blk_seen[1][63:0], 64'hf8f9fafbfcfdff00);
        run_frame(N0, C0, 2, 10);
        check_eq("hold_pt2", pt_got[1], 128'hae2d8a571e03ac9c9eb76fac45af8e51);

        // counter wrap inside a frame, then cleared by a key reload
        ct_blk[0] = {$urandom, $urandom, $urandom, $urandom};
        ct_blk[1] = {$urandom, $urandom, $urandom, $urandom};
        run_frame(64'h0123456789abcdef, 64'hffff_ffff_ffff_ffff, 2, 1);
        check_eq("wrap_ctr_zero", blk_seen[1][63:0], 64'h0);
        check_eq("wrap_err_set", bus.ctr_wrap_err, 1);
        load_key();

        // abort while the core is computing keystream
        force_tlow = 6;
        repeat (2) @(negedge clk);
        send_hdr(N0, C0, h, ok);
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n = 0;
        while (!bus.hdr_ready && n < 100) begin
            check_eq("abort_no_ct", bus.ct_ready, 0);
            @(negedge clk);
            n++;
        end
        check_eq("abort_hdr_ready", bus.hdr_ready, 1);
        check_eq("abort_return_cycle", cyc, h + 3 + last_tlow);
        force_tlow = 0;
        repeat (2) @(negedge clk);
        ct_blk[0] = 128'h874d6191b620e3261bef6864990db6ce;
        run_frame(N0, C0, 1, 0);
        check_eq("post_abort_pt", pt_got[0], 128'h6bc1bee22e409f96e93d7e117393172a);

        // abort while plaintext is waiting
        send_hdr(64'h1111, 64'h22, h, ok);
        wait_ct_ready(ok);
        bus.ct_valid = 1'b1; bus.ct_data = 128'h5a; bus.ct_last = 1'b0;
        @(negedge clk);
        bus.ct_valid = 1'b0;
        check_eq("out_pt_valid", bus.pt_valid, 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("out_abort_pt_valid", bus.pt_valid, 0);
        check_eq("out_abort_hdr_ready", bus.hdr_ready, 1);

        // key_init beats hdr_valid in the same cycle
        nc = next_count;
        bus.key_init = 1'b1;
        bus.hdr_valid = 1'b1;
        #1;
        check_eq("keyinit_hdr_ready", bus.hdr_ready, 0);
        @(negedge clk);
        bus.key_init = 1'b0;
        bus.hdr_valid = 1'b0;
        check_eq("keyinit_loaded_drop", bus.key_loaded, 0);
        n = 0;
        while (!bus.key_loaded && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("keyinit_reloaded", bus.key_loaded, 1);
        check_eq("keyinit_no_next", next_count, nc);
        check_eq("keyinit_hdr_idle", bus.hdr_ready, 1);

        for (int f = 0; f < 10; f++) rand_frame();

        // asynchronous reset in the middle of a frame
        send_hdr(N0, C0, h, ok);
        wait_ct_ready(ok);
        bus.ct_valid = 1'b1; bus.ct_data = 128'hdead_beef; bus.ct_last = 1'b0;
        @(negedge clk);
        bus.ct_valid = 1'b0;
        check_eq("pre_reset_pt_valid", bus.pt_valid, 1);
        reset = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        load_key();
        rand_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
